// File: rtl/tri_subdivide.sv
// Depth-first subdivision controller: splits triangles through the external
// combinational bisect stage until every edge spans at most MAX_SPAN in x and y.
module tri_subdivide #(
  parameter int STACK_DEPTH = 8,
  parameter int MAX_SPAN    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [143:0] in_tri,
  output logic [143:0] bis_tri,
  output logic         bis_select,
  input  logic [143:0] bis_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [143:0] out_tri,
  output logic         busy,
  output logic         overflow
);

  // Triangle layout, MSB first: p.x p.y p.z q.x q.y q.z r.x r.y r.z
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vtx_t;

  typedef struct packed {
    vtx_t p;
    vtx_t q;
    vtx_t r;
  } tri_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVAL    = 3'd1,
    SPLIT_A = 3'd2,
    SPLIT_B = 3'd3,
    EMIT    = 3'd4
  } state_t;

  localparam int              SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int              IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [16:0]     SPAN  = 17'(MAX_SPAN);
  localparam logic [SP_W-1:0] FULL  = SP_W'(STACK_DEPTH);

  function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic edge_fits(input vtx_t a, input vtx_t b);
    return ({1'b0, abs_diff(a.x, b.x)} <= SPAN) && ({1'b0, abs_diff(a.y, b.y)} <= SPAN);
  endfunction

  function automatic logic is_small(input tri_t t);
    return edge_fits(t.p, t.q) && edge_fits(t.q, t.r) && edge_fits(t.r, t.p);
  endfunction

  state_t          state_q, state_d;
  tri_t            cur_q, cur_d;
  tri_t            half0_q, half0_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            push;
  tri_t            stack_q [STACK_DEPTH];
  logic [IDX_W-1:0] push_idx, pop_idx;

  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    half0_d = half0_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cur_d   = in_tri;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (is_small(cur_q)) begin
          state_d = EMIT;
        end else if (sp_q == FULL) begin
          // No room to defer a half: emit oversized and remember it.
          ovf_d   = 1'b1;
          state_d = EMIT;
        end else begin
          state_d = SPLIT_A;
        end
      end
      SPLIT_A: begin
        half0_d = bis_result;
        state_d = SPLIT_B;
      end
      SPLIT_B: begin
        push    = 1'b1;
        sp_d    = sp_q + SP_W'(1);
        cur_d   = half0_q;
        state_d = EVAL;
      end
      EMIT: begin
        if (out_ready) begin
          if (sp_q == '0) begin
            state_d = IDLE;
          end else begin
            cur_d   = stack_q[pop_idx];
            sp_d    = sp_q - SP_W'(1);
            state_d = EVAL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      half0_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      half0_q <= half0_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
    end
  end

  // Stack contents need no reset; sp alone defines what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= bis_result;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == EMIT);
  assign bis_select = (state_q == SPLIT_B);
  assign bis_tri    = cur_q;
  assign out_tri    = cur_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_tri_subdivide.sv
// Bench for tri_subdivide: directed vector table, multi-cycle corner cases and
// randomized triangles against a queue-based depth-first reference model.
module tb_tri_subdivide;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vtx_t;

  typedef struct packed {
    vtx_t p;
    vtx_t q;
    vtx_t r;
  } tri_t;

  typedef struct {
    tri_t in;
    int   n;
    tri_t e0;
    tri_t e1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: depth 8, span 4.  Instance B: depth 1, span 1.
  logic         rst_a, in_valid_a, in_ready_a, bis_select_a, out_valid_a, out_ready_a, busy_a, overflow_a;
  logic [143:0] in_tri_a, bis_tri_a, bis_result_a, out_tri_a;
  logic         rst_b, in_valid_b, in_ready_b, bis_select_b, out_valid_b, out_ready_b, busy_b, overflow_b;
  logic [143:0] in_tri_b, bis_tri_b, bis_result_b, out_tri_b;

  int n_tests = 0;
  int n_fail  = 0;
  tri_t got_a[$];
  tri_t got_b[$];
  tri_t exp_q[$];
  int sp_max_b = 0;

  function automatic int cheb(vtx_t a, vtx_t b);
    int dx, dy;
    dx = int'(a.x) - int'(b.x);
    dy = int'(a.y) - int'(b.y);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx > dy) ? dx : dy;
  endfunction

  // Longest-edge bisector standing in for the downstream bisect stage.
  function automatic tri_t bisect(tri_t t, logic sel);
    vtx_t v[3];
    int   e[3];
    int   k;
    vtx_t a, b, c, m;
    tri_t res;
    v[0] = t.p; v[1] = t.q; v[2] = t.r;
    for (int i = 0; i < 3; i++) e[i] = cheb(v[i], v[(i + 1) % 3]);
    k = 0;
    if (e[1] > e[k]) k = 1;
    if (e[2] > e[k]) k = 2;
    a = v[k]; b = v[(k + 1) % 3]; c = v[(k + 2) % 3];
    m.x = 16'(({16'b0, a.x} + {16'b0, b.x}) >> 1);
    m.y = 16'(({16'b0, a.y} + {16'b0, b.y}) >> 1);
    m.z = 16'(({16'b0, a.z} + {16'b0, b.z}) >> 1);
    if (sel) begin res.p = m; res.q = b; res.r = c; end
    else     begin res.p = a; res.q = m; res.r = c; end
    return res;
  endfunction

  function automatic bit ref_small(tri_t t, int span);
    return cheb(t.p, t.q) <= span && cheb(t.q, t.r) <= span && cheb(t.r, t.p) <= span;
  endfunction

  // Depth-first reference: emit small or stack-blocked triangles, else split.
  task automatic ref_run(input tri_t t, input int depth, input int span, output bit ovf);
    tri_t stk[$];
    tri_t cur;
    exp_q.delete();
    ovf = 1'b0;
    cur = t;
    for (int g = 0; g < 20000; g++) begin
      if (ref_small(cur, span) || stk.size() >= depth) begin
        if (!ref_small(cur, span)) ovf = 1'b1;
        exp_q.push_back(cur);
        if (stk.size() == 0) break;
        cur = stk.pop_back();
      end else begin
        stk.push_back(bisect(cur, 1'b1));
        cur = bisect(cur, 1'b0);
      end
    end
  endtask

  function automatic tri_t mk(int px, int py, int pz, int qx, int qy, int qz, int rx, int ry, int rz);
    tri_t t;
    t.p.x = 16'(px); t.p.y = 16'(py); t.p.z = 16'(pz);
    t.q.x = 16'(qx); t.q.y = 16'(qy); t.q.z = 16'(qz);
    t.r.x = 16'(rx); t.r.y = 16'(ry); t.r.z = 16'(rz);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  assign bis_result_a = bisect(tri_t'(bis_tri_a), bis_select_a);
  assign bis_result_b = bisect(tri_t'(bis_tri_b), bis_select_b);

  tri_subdivide #(.STACK_DEPTH(8), .MAX_SPAN(4)) u_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_tri(in_tri_a),
    .bis_tri(bis_tri_a), .bis_select(bis_select_a), .bis_result(bis_result_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_tri(out_tri_a),
    .busy(busy_a), .overflow(overflow_a));

  tri_subdivide #(.STACK_DEPTH(1), .MAX_SPAN(1)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_tri(in_tri_b),
    .bis_tri(bis_tri_b), .bis_select(bis_select_b), .bis_result(bis_result_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_tri(out_tri_b),
    .busy(busy_b), .overflow(overflow_b));

  always @(negedge clk) begin
    if (out_valid_a && out_ready_a) got_a.push_back(tri_t'(out_tri_a));
    if (out_valid_b && out_ready_b) got_b.push_back(tri_t'(out_tri_b));
    if (int'(u_b.sp_q) > sp_max_b) sp_max_b = int'(u_b.sp_q);
  end

  // Present one triangle to A, then run until it is idle again.
  task automatic run_a(input tri_t t, input bit bp, input int budget);
    @(posedge clk); #1;
    in_valid_a = 1'b1; in_tri_a = t;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      out_ready_a = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (!busy_a) break;
    end
    chk("run_done", busy_a, 0);
    out_ready_a = 1'b1;
  endtask

  task automatic cmp_list(input string nm);
    chk({nm, "_count"}, got_a.size(), exp_q.size());
    for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) chk({nm, "_tri"}, got_a[i], exp_q[i]);
  endtask

  vec_t vecs[4];
  tri_t t0, t1, t3;
  bit   ovf, ovf_acc;
  int   bbox_bad;

  initial begin
    t0 = mk(0,0,0, 4,0,0, 0,4,0);
    t1 = mk(0,0,0, 8,0,0, 4,2,0);
    t3 = mk(0,8,10, 2,4,20, 0,0,30);
    vecs[0] = '{t0, 1, t0, '0};
    vecs[1] = '{t1, 2, mk(0,0,0, 4,0,0, 4,2,0), mk(4,0,0, 8,0,0, 4,2,0)};
    vecs[2] = '{mk(10,10,0, 14,14,65535, 10,14,3), 1, mk(10,10,0, 14,14,65535, 10,14,3), '0};
    vecs[3] = '{t3, 2, mk(0,0,30, 0,4,20, 2,4,20), mk(0,4,20, 0,8,10, 2,4,20)};

    rst_a = 1'b1; in_valid_a = 1'b0; in_tri_a = '0; out_ready_a = 1'b1;
    rst_b = 1'b1; in_valid_b = 1'b0; in_tri_b = '0; out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_overflow", overflow_a, 0);
    chk("rst_bis_select", bis_select_a, 0);
    chk("rst_out_tri", out_tri_a, 0);
    chk("rst_b_busy", busy_b, 0);

    // Small triangle latency: accepted at N, EVAL at N+1, EMIT at N+2.
    got_a.delete();
    @(posedge clk); #1; in_valid_a = 1'b1; in_tri_a = t0;
    @(posedge clk); #1; in_valid_a = 1'b0;
    @(negedge clk);
    chk("lat_eval_valid", out_valid_a, 0);
    chk("lat_eval_ready", in_ready_a, 0);
    @(negedge clk);
    chk("lat_emit_valid", out_valid_a, 1);
    chk("lat_emit_tri", out_tri_a, t0);
    @(negedge clk);
    chk("lat_idle_ready", in_ready_a, 1);
    chk("lat_count", got_a.size(), 1);

    foreach (vecs[v]) begin
      got_a.delete();
      run_a(vecs[v].in, 1'b0, 200);
      chk("vec_count", got_a.size(), vecs[v].n);
      if (got_a.size() > 0) chk("vec_out0", got_a[0], vecs[v].e0);
      if (vecs[v].n > 1 && got_a.size() > 1) chk("vec_out1", got_a[1], vecs[v].e1);
      chk("vec_overflow", overflow_a, 0);
    end

    // Backpressure: hold each EMIT for several cycles.
    got_a.delete(); out_ready_a = 1'b0;
    @(posedge clk); #1; in_valid_a = 1'b1; in_tri_a = t1;
    @(posedge clk); #1; in_valid_a = 1'b0;
    for (int h = 0; h < 2; h++) begin
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (out_valid_a) break;
      end
      chk("bp_reach", out_valid_a, 1);
      for (int s = 0; s < 5; s++) begin
        if (s > 0) @(negedge clk);
        chk("bp_hold_valid", out_valid_a, 1);
        chk("bp_hold_tri", out_tri_a, (h == 0) ? vecs[1].e0 : vecs[1].e1);
      end
      @(posedge clk); #1; out_ready_a = 1'b1;
      @(posedge clk); #1; out_ready_a = 1'b0;
    end
    for (int c = 0; c < 50 && busy_a; c++) @(negedge clk);
    chk("bp_done", busy_a, 0);
    chk("bp_count", got_a.size(), 2);
    if (got_a.size() == 2) begin
      chk("bp_out0", got_a[0], vecs[1].e0);
      chk("bp_out1", got_a[1], vecs[1].e1);
    end
    out_ready_a = 1'b1;

    // Reset while in SPLIT_B.
    got_a.delete();
    @(posedge clk); #1; in_valid_a = 1'b1; in_tri_a = t1;
    @(posedge clk); #1; in_valid_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_split_b_select", bis_select_a, 1);
    rst_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 1);
    chk("mid_rst_count", got_a.size(), 0);
    run_a(t0, 1'b0, 100);
    chk("mid_fresh_count", got_a.size(), 1);
    if (got_a.size() > 0) chk("mid_fresh_tri", got_a[0], t0);

    // Input gating: second triangle held valid during the first's subdivision.
    got_a.delete();
    @(posedge clk); #1; in_valid_a = 1'b1; in_tri_a = t1;
    @(posedge clk); #1; in_tri_a = t3;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready_a) break;
    end
    chk("gate_reach", in_ready_a, 1);
    chk("gate_count_at_accept", got_a.size(), 2);
    @(posedge clk); #1; in_valid_a = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy_a) break;
    end
    chk("gate_done", busy_a, 0);
    chk("gate_total", got_a.size(), 4);
    if (got_a.size() == 4) begin
      chk("gate_out2", got_a[2], vecs[3].e0);
      chk("gate_out3", got_a[3], vecs[3].e1);
    end

    // Randomized triangles with random backpressure.
    ovf_acc = 1'b0;
    for (int r = 0; r < 30; r++) begin
      tri_t t;
      t = mk($urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 65535),
             $urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 65535),
             $urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 65535));
      ref_run(t, 8, 4, ovf);
      ovf_acc |= ovf;
      got_a.delete();
      run_a(t, 1'b1, 6000);
      cmp_list("rand");
      chk("rand_overflow", overflow_a, ovf_acc);
    end

    // Overflow on the depth-1 instance.
    got_b.delete(); sp_max_b = 0;
    @(posedge clk); #1; in_valid_b = 1'b1; in_tri_b = mk(0,0,0, 64,0,0, 0,64,0);
    @(posedge clk); #1; in_valid_b = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid_b) break;
    end
    chk("ovf_first_valid", out_valid_b, 1);
    chk("ovf_flag_at_first", overflow_b, 1);
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (!busy_b) break;
    end
    chk("ovf_idle_busy", busy_b, 0);
    chk("ovf_idle_ready", in_ready_b, 1);
    chk("ovf_sp_bound", sp_max_b <= 1, 1);
    bbox_bad = 0;
    foreach (got_b[i])
      if (got_b[i].p.x > 64 || got_b[i].p.y > 64 || got_b[i].q.x > 64 ||
          got_b[i].q.y > 64 || got_b[i].r.x > 64 || got_b[i].r.y > 64) bbox_bad++;
    chk("ovf_bbox", bbox_bad, 0);
    ref_run(mk(0,0,0, 64,0,0, 0,64,0), 1, 1, ovf);
    chk("ovf_model_flag", overflow_b, ovf);
    chk("ovf_count", got_b.size(), exp_q.size());
    for (int i = 0; i < got_b.size() && i < exp_q.size(); i++) chk("ovf_tri", got_b[i], exp_q[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
